// File: rtl/sm_move_ctrl.sv
// Motion sequencer for the stepper pulse generator.
// Turns a move command into an accel / cruise / decel period profile on N,
// counts the generator's step pulses and reports completion or abort.
module sm_move_ctrl #(
  parameter int SIZE   = 16,
  parameter int STEP_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              dir_in,
  input  logic [STEP_W-1:0] steps,
  input  logic [SIZE-1:0]   n_start,
  input  logic [SIZE-1:0]   n_min,
  input  logic [SIZE-1:0]   acc,
  input  logic              abort,
  input  logic              step_fb,
  output logic              drv_en_SM,
  output logic [SIZE-1:0]   N,
  output logic              drv_dir,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [STEP_W-1:0] step_cnt
);

  // Compare width wide enough for both remaining-step and ramp counts.
  localparam int CW = ((STEP_W > SIZE + 1) ? STEP_W : SIZE + 1) + 1;

  localparam logic [SIZE-1:0]   N_ONE    = {{(SIZE-1){1'b0}}, 1'b1};
  localparam logic [STEP_W-1:0] CNT_ONE  = {{(STEP_W-1){1'b0}}, 1'b1};
  localparam logic [SIZE:0]     RAMP_ONE = {{SIZE{1'b0}}, 1'b1};
  localparam logic [CW-1:0]     CW_ONE   = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCEL  = 3'd1,
    CRUISE = 3'd2,
    DECEL  = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              stepFb_q;
  logic              dir_q, dir_d;
  logic              aborted_q, aborted_d;
  logic [SIZE-1:0]   n_q, n_d;
  logic [SIZE-1:0]   nStart_q, nStart_d;
  logic [SIZE-1:0]   nMin_q, nMin_d;
  logic [SIZE-1:0]   acc_q, acc_d;
  logic [STEP_W-1:0] rem_q, rem_d;
  logic [STEP_W-1:0] cnt_q, cnt_d;
  logic [SIZE:0]     ramp_q, ramp_d;

  logic              stepSeen;
  logic              moving;
  logic [SIZE:0]     accFloor;
  logic [SIZE:0]     decelSum;
  logic [SIZE:0]     rampInc;
  logic [SIZE:0]     rampDec;
  logic [SIZE-1:0]   accelN;
  logic [SIZE-1:0]   decelN;
  logic [STEP_W-1:0] remAfter;
  logic [CW-1:0]     remLeftW;
  logic [CW-1:0]     rampW;
  logic [CW-1:0]     rampIncW;

  // Rising edge of the generator's step output, and the profile arithmetic
  // for the next period, evaluated one bit wider than SIZE so nothing wraps.
  assign stepSeen = step_fb & ~stepFb_q;
  assign moving   = (state_q == ACCEL) || (state_q == CRUISE) || (state_q == DECEL);
  assign accFloor = {1'b0, nMin_q} + {1'b0, acc_q};
  assign accelN   = ({1'b0, n_q} >= accFloor) ? (n_q - acc_q) : nMin_q;
  assign decelSum = {1'b0, n_q} + {1'b0, acc_q};
  assign decelN   = (decelSum > {1'b0, nStart_q}) ? nStart_q : decelSum[SIZE-1:0];
  assign rampInc  = ramp_q + RAMP_ONE;
  assign rampDec  = (ramp_q == '0) ? '0 : (ramp_q - RAMP_ONE);
  assign remAfter = rem_q - CNT_ONE;
  assign remLeftW = CW'(remAfter) - CW_ONE;
  assign rampW    = CW'(ramp_q);
  assign rampIncW = CW'(rampInc);

  // State, latched command and step-edge register, cleared by the active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      stepFb_q  <= 1'b0;
      dir_q     <= 1'b0;
      aborted_q <= 1'b0;
      n_q       <= '0;
      nStart_q  <= '0;
      nMin_q    <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      ramp_q    <= '0;
    end else begin
      state_q   <= state_d;
      stepFb_q  <= step_fb;
      dir_q     <= dir_d;
      aborted_q <= aborted_d;
      n_q       <= n_d;
      nStart_q  <= nStart_d;
      nMin_q    <= nMin_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      ramp_q    <= ramp_d;
    end
  end

  // Next-state logic: command capture in IDLE, per-step profile update while
  // moving, abort handling, and the single STOP cycle. The step that triggers
  // the switch into DECEL keeps the current period so the peak is held for
  // one more step and the profile stays symmetric.
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    aborted_d = aborted_q;
    n_d       = n_q;
    nStart_d  = nStart_q;
    nMin_d    = nMin_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    ramp_d    = ramp_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          dir_d     = dir_in;
          nStart_d  = n_start;
          nMin_d    = (n_min < n_start) ? n_min : n_start;
          acc_d     = (acc == '0) ? N_ONE : acc;
          rem_d     = steps;
          ramp_d    = '0;
          cnt_d     = '0;
          aborted_d = 1'b0;
          if (steps == '0) begin
            state_d = STOP;
          end else begin
            state_d = ACCEL;
            n_d     = n_start;
          end
        end
      end

      ACCEL, CRUISE, DECEL: begin
        if (stepSeen) begin
          rem_d = remAfter;
          cnt_d = cnt_q + CNT_ONE;
        end
        if (abort) begin
          state_d   = STOP;
          aborted_d = 1'b1;
        end else if (stepSeen) begin
          if (rem_q == CNT_ONE) begin
            state_d = STOP;
          end else if (state_q == ACCEL) begin
            ramp_d = rampInc;
            if (remLeftW <= rampIncW) begin
              state_d = DECEL;
            end else begin
              n_d = accelN;
              if (accelN == nMin_q) begin
                state_d = CRUISE;
              end
            end
          end else if (state_q == CRUISE) begin
            if (remLeftW <= rampW) begin
              state_d = DECEL;
            end
          end else begin
            n_d    = decelN;
            ramp_d = rampDec;
          end
        end
      end

      STOP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status outputs decode directly from the state register; the rest are latched values.
  assign drv_en_SM = moving;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == STOP);
  assign N         = n_q;
  assign drv_dir   = dir_q;
  assign aborted   = aborted_q;
  assign step_cnt  = cnt_q;

endmodule

// File: tb/tb_sm_move_ctrl.sv
// Testbench for sm_move_ctrl: directed profile scenarios, random moves and a
// step-indexed profile model compared against the outputs on every cycle.
module tb_sm_move_ctrl;

  localparam int SIZE   = 16;
  localparam int STEP_W = 24;

  logic              clk;
  logic              rst;
  logic              start;
  logic              dir_in;
  logic [STEP_W-1:0] steps;
  logic [SIZE-1:0]   n_start;
  logic [SIZE-1:0]   n_min;
  logic [SIZE-1:0]   acc;
  logic              abort;
  logic              step_fb;
  logic              drv_en_SM;
  logic [SIZE-1:0]   N;
  logic              drv_dir;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [STEP_W-1:0] step_cnt;

  int tests;
  int failures;

  int stepN[$];
  logic lastDone, lastEn, lastAborted;
  logic [STEP_W-1:0] lastCnt;

  // Model of the move: phase 0 idle, 1 stepping, 2 the one end-of-move cycle.
  int mPhase, mK, mS, mNs, mNm, mAcc, mN;
  bit mDir, mAborted, mPrevFb;

  sm_move_ctrl #(.SIZE(SIZE), .STEP_W(STEP_W)) dut (
    .clk(clk), .rst(rst), .start(start), .dir_in(dir_in), .steps(steps),
    .n_start(n_start), .n_min(n_min), .acc(acc), .abort(abort),
    .step_fb(step_fb), .drv_en_SM(drv_en_SM), .N(N), .drv_dir(drv_dir),
    .busy(busy), .done(done), .aborted(aborted), .step_cnt(step_cnt)
  );

  // 50 MHz clock
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Period that must be in force after k steps of an s-step move, derived
  // step by step from the ramp rules with plain integers.
  function automatic int profAt(int s, int ns, int nm, int a, int k);
    int nmE = (nm < ns) ? nm : ns;
    int aE = (a == 0) ? 1 : a;
    int n = ns;
    int ramp = 0;
    int phase = 0;
    for (int i = 1; i <= k; i++) begin
      int left = s - i;
      if (phase == 0) begin
        ramp++;
        if (left - 1 <= ramp) phase = 2;
        else begin
          n = (n >= nmE + aE) ? n - aE : nmE;
          if (n == nmE) phase = 1;
        end
      end else if (phase == 1) begin
        if (left - 1 <= ramp) phase = 2;
      end else begin
        n = (n + aE > ns) ? ns : n + aE;
        ramp = (ramp > 0) ? ramp - 1 : 0;
      end
    end
    return n;
  endfunction

  // Reference model advanced on each rising edge from the inputs the DUT sees.
  always @(posedge clk) begin
    if (!rst) begin
      mPhase   <= 0;
      mK       <= 0;
      mN       <= 0;
      mDir     <= 1'b0;
      mAborted <= 1'b0;
      mPrevFb  <= 1'b0;
    end else begin
      mPrevFb <= step_fb;
      if (mPhase == 0) begin
        if (start) begin
          mS       <= int'(steps);
          mNs      <= int'(n_start);
          mNm      <= int'(n_min);
          mAcc     <= int'(acc);
          mK       <= 0;
          mAborted <= 1'b0;
          mDir     <= dir_in;
          if (steps == 0) mPhase <= 2;
          else begin
            mPhase <= 1;
            mN     <= int'(n_start);
          end
        end
      end else if (mPhase == 1) begin
        if (step_fb && !mPrevFb) mK <= mK + 1;
        if (abort) begin
          mPhase   <= 2;
          mAborted <= 1'b1;
        end else if (step_fb && !mPrevFb) begin
          if (mK + 1 == mS) mPhase <= 2;
          else mN <= profAt(mS, mNs, mNm, mAcc, mK + 1);
        end
      end else begin
        mPhase <= 0;
      end
    end
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    tests++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkSeq(input string name, input int expSeq[$]);
    checkOutput({name, " step count"}, stepN.size(), expSeq.size());
    for (int i = 0; i < expSeq.size() && i < stepN.size(); i++)
      checkOutput($sformatf("%s N at step %0d", name, i + 1), stepN[i], expSeq[i]);
  endtask

  // Every-cycle comparison of all outputs against the model.
  task automatic compareLoop();
    forever begin
      @(negedge clk);
      tests++;
      if (drv_en_SM !== (mPhase == 1) || busy !== (mPhase != 0) ||
          done !== (mPhase == 2) || N !== mN[SIZE-1:0] || drv_dir !== mDir ||
          aborted !== mAborted || step_cnt !== mK[STEP_W-1:0]) begin
        failures++;
        $display("[TB] FAIL cycle compare t=%0t: got en=%b busy=%b done=%b N=%0d dir=%b ab=%b cnt=%0d, expected en=%b busy=%b done=%b N=%0d dir=%b ab=%b cnt=%0d",
                 $time, drv_en_SM, busy, done, N, drv_dir, aborted, step_cnt,
                 (mPhase == 1), (mPhase != 0), (mPhase == 2), mN, mDir, mAborted, mK);
      end
    end
  endtask

  task automatic applyStimulus(input int s, input bit d, input int ns, input int nm,
                               input int a, input bit withAbort);
    @(negedge clk);
    steps   = STEP_W'(s);
    dir_in  = d;
    n_start = SIZE'(ns);
    n_min   = SIZE'(nm);
    acc     = SIZE'(a);
    start   = 1'b1;
    abort   = withAbort;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  // One step pulse held for 'hold' cycles; records N in force for this step
  // and the outputs seen the cycle after the edge.
  task automatic pulseStep(input int hold);
    stepN.push_back(int'(N));
    step_fb = 1'b1;
    @(negedge clk);
    lastDone    = done;
    lastEn      = drv_en_SM;
    lastCnt     = step_cnt;
    lastAborted = aborted;
    repeat (hold - 1) @(negedge clk);
    step_fb = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int expSeq[$];
    int s, guard;
    tests    = 0;
    failures = 0;
    rst      = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    step_fb  = 1'b0;
    dir_in   = 1'b0;
    steps    = '0;
    n_start  = '0;
    n_min    = '0;
    acc      = '0;
    fork
      compareLoop();
    join_none

    checkOutput("model trapezoid k6", profAt(10, 100, 40, 20, 6), 40);
    checkOutput("model trapezoid k7", profAt(10, 100, 40, 20, 7), 60);
    checkOutput("model triangle k3", profAt(6, 100, 10, 10, 3), 80);
    checkOutput("model triangle k4", profAt(6, 100, 10, 10, 4), 90);
    checkOutput("model acc0 k3", profAt(8, 5, 2, 0, 3), 2);

    repeat (3) @(negedge clk);
    checkOutput("reset N", N, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset step_cnt", step_cnt, 0);
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] trapezoid");
    applyStimulus(10, 1'b1, 100, 40, 20, 1'b0);
    checkOutput("trap start N", N, 100);
    checkOutput("trap start en", drv_en_SM, 1);
    checkOutput("trap start dir", drv_dir, 1);
    stepN.delete();
    repeat (10) pulseStep(1);
    expSeq = '{100, 80, 60, 40, 40, 40, 40, 60, 80, 100};
    checkSeq("trap", expSeq);
    checkOutput("trap done", lastDone, 1);
    checkOutput("trap en in stop", lastEn, 0);
    checkOutput("trap step_cnt", lastCnt, 10);

    $display("[TB] triangle");
    applyStimulus(6, 1'b0, 100, 10, 10, 1'b0);
    stepN.delete();
    repeat (6) pulseStep(1);
    expSeq = '{100, 90, 80, 80, 90, 100};
    checkSeq("tri", expSeq);
    checkOutput("tri done", lastDone, 1);
    checkOutput("tri step_cnt", lastCnt, 6);

    $display("[TB] zero steps");
    applyStimulus(0, 1'b1, 100, 40, 20, 1'b0);
    checkOutput("zero done", done, 1);
    checkOutput("zero busy", busy, 1);
    checkOutput("zero en", drv_en_SM, 0);
    @(negedge clk);
    checkOutput("zero done after", done, 0);
    checkOutput("zero busy after", busy, 0);

    $display("[TB] abort");
    applyStimulus(50, 1'b1, 100, 40, 20, 1'b0);
    repeat (3) pulseStep(1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort en", drv_en_SM, 0);
    checkOutput("abort done", done, 1);
    checkOutput("abort flag", aborted, 1);
    checkOutput("abort step_cnt", step_cnt, 3);
    @(negedge clk);
    checkOutput("abort flag held", aborted, 1);
    applyStimulus(2, 1'b0, 100, 40, 20, 1'b0);
    checkOutput("abort cleared by start", aborted, 0);
    repeat (2) pulseStep(1);
    checkOutput("after abort done", lastDone, 1);

    applyStimulus(5, 1'b1, 100, 40, 20, 1'b0);
    pulseStep(1);
    step_fb = 1'b1;
    abort   = 1'b1;
    @(negedge clk);
    step_fb = 1'b0;
    abort   = 1'b0;
    checkOutput("abort+step step_cnt", step_cnt, 2);
    checkOutput("abort+step flag", aborted, 1);
    @(negedge clk);

    applyStimulus(3, 1'b1, 100, 40, 20, 1'b1);
    checkOutput("start beats abort busy", busy, 1);
    checkOutput("start beats abort flag", aborted, 0);
    repeat (3) pulseStep(1);
    checkOutput("start beats abort done", lastDone, 1);

    $display("[TB] reset mid-move");
    applyStimulus(10, 1'b1, 100, 40, 20, 1'b0);
    repeat (5) pulseStep(1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midreset N", N, 0);
    checkOutput("midreset en", drv_en_SM, 0);
    checkOutput("midreset done", done, 0);
    checkOutput("midreset dir", drv_dir, 0);
    checkOutput("midreset step_cnt", step_cnt, 0);
    rst = 1'b1;
    applyStimulus(6, 1'b1, 100, 10, 10, 1'b0);
    stepN.delete();
    repeat (6) pulseStep(1);
    expSeq = '{100, 90, 80, 80, 90, 100};
    checkSeq("post-reset tri", expSeq);
    checkOutput("post-reset step_cnt", lastCnt, 6);

    $display("[TB] corner inputs");
    applyStimulus(4, 1'b0, 100, 200, 20, 1'b0);
    stepN.delete();
    repeat (4) pulseStep(1);
    expSeq = '{100, 100, 100, 100};
    checkSeq("nmin above nstart", expSeq);

    applyStimulus(8, 1'b1, 5, 2, 0, 1'b0);
    stepN.delete();
    repeat (8) pulseStep(1);
    expSeq = '{5, 4, 3, 2, 2, 3, 4, 5};
    checkSeq("acc zero", expSeq);

    applyStimulus(6, 1'b1, 100, 10, 10, 1'b0);
    stepN.delete();
    repeat (2) pulseStep(1);
    steps   = STEP_W'(3);
    n_start = SIZE'(50);
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) pulseStep(1);
    expSeq = '{100, 90, 80, 80, 90, 100};
    checkSeq("start while busy", expSeq);
    checkOutput("start while busy step_cnt", lastCnt, 6);

    applyStimulus(3, 1'b0, 100, 40, 20, 1'b0);
    pulseStep(5);
    checkOutput("held step_fb step_cnt", step_cnt, 1);
    repeat (2) pulseStep(1);
    checkOutput("held step_fb done", lastDone, 1);

    $display("[TB] random moves");
    for (int m = 0; m < 20; m++) begin
      s = $urandom_range(0, 40);
      applyStimulus(s, 1'($urandom_range(0, 1)), $urandom_range(20, 300),
                    $urandom_range(5, 350), $urandom_range(0, 40),
                    ($urandom_range(0, 7) == 0));
      guard = 0;
      while (busy && guard < s + 10) begin
        if ($urandom_range(0, 29) == 0) begin
          abort = 1'b1;
          @(negedge clk);
          abort = 1'b0;
        end else begin
          if ($urandom_range(0, 9) == 0) begin
            steps = STEP_W'($urandom_range(1, 9));
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
          end
          pulseStep($urandom_range(1, 3));
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        guard++;
      end
      repeat (2) @(negedge clk);
      checkOutput($sformatf("random move %0d returns idle", m), busy, 0);
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  // Hard bound on total run time.
  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/sm_move_ctrl.md
Name: sm_move_ctrl

Overview:
- Motion sequencer for the stepper-motor pulse generator.
- Accepts a move command (step count, direction, ramp settings).
- Drives the generator's enable and period input N with a trapezoidal (or triangular) accel/cruise/decel profile.
- Counts the generated step pulses and signals completion to the host/command logic.

Parameters:
SIZE, 16, width of period values (N, n_start, n_min, acc)
STEP_W, 24, width of step-count values

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  synchronous reset, active-low (0 = reset), sampled on posedge clk
start  in  1  one-cycle move request; sampled only in IDLE
dir_in  in  1  move direction, latched with start
steps  in  STEP_W  number of steps to execute, latched with start
n_start  in  SIZE  start/stop period (slowest), latched with start
n_min  in  SIZE  cruise period (fastest), latched with start
acc  in  SIZE  period change per step during ramps, latched with start
abort  in  1  immediate stop request
step_fb  in  1  drv_step output of the pulse generator
drv_en_SM  out  1  enable to pulse generator
N  out  SIZE  period to pulse generator
drv_dir  out  1  direction to driver
busy  out  1  high from ACCEL entry until return to IDLE
done  out  1  one-cycle pulse at move end
aborted  out  1  high with done if the move ended by abort; cleared on next start
step_cnt  out  STEP_W  steps executed in current/last move

Behaviour:
- Reset (rst=0):
  - state=IDLE; drv_en_SM=0, N=0, drv_dir=0, busy=0, done=0, aborted=0, step_cnt=0.
  - Edge-detect register and all latches cleared.
  - Reset mid-move stops immediately, with no done pulse.
- Step detection: step = step_fb & ~step_fb_d (one registered stage). Only steps seen in ACCEL/CRUISE/DECEL are counted.
- States: IDLE, ACCEL, CRUISE, DECEL, STOP.
- IDLE, start=1 at cycle t:
  - Latch inputs.
  - n_min_eff = min(n_min, n_start); acc_eff = max(acc, 1).
  - rem=steps, ramp=0, step_cnt=0, aborted=0.
  - If steps=0: go to STOP at t+1 (drv_en_SM stays 0).
  - Else at t+1: state=ACCEL, drv_en_SM=1, N=n_start, drv_dir=dir_in, busy=1.
- Every detected step in a moving state, updated on the following clock:
  - rem-=1, step_cnt+=1.
  - If rem was 1: go to STOP regardless of state.
- ACCEL, per step (rem>1 before the step):
  - ramp+=1.
  - N = (N >= n_min_eff+acc_eff) ? N-acc_eff : n_min_eff.
  - If the new N equals n_min_eff: go to CRUISE.
  - If rem-1 <= ramp+1: go to DECEL (triangle profile); this takes priority over CRUISE.
- CRUISE, per step: N holds; if rem-1 <= ramp: go to DECEL.
- DECEL, per step: N = min(N+acc_eff, n_start); ramp-=1, saturating at 0.
- Ramp arithmetic: SIZE+1 bits internally, so no wrap.
- STOP (one cycle): drv_en_SM=0, done=1, busy=1; next cycle IDLE, busy=0, N holds its last value.
- abort=1 in ACCEL/CRUISE/DECEL:
  - Next cycle: STOP, aborted=1, step_cnt frozen.
  - A step detected in the same cycle as abort is still counted.
- abort in IDLE/STOP: ignored.
- start outside IDLE: ignored; no queuing.
- start and abort together in IDLE: start wins.
- Ranges: steps up to 2^STEP_W-1; step_cnt never wraps within a move.

Test Plan:
- Basic trapezoid: n_start=100, n_min=40, acc=20, steps=10.
  - N sequence across steps: 100,80,60,40,40,40,40,60,80,100.
  - done one cycle after the 10th step edge; step_cnt=10; drv_en_SM low in the STOP cycle.
- Triangle: n_start=100, n_min=10, acc=10, steps=6.
  - N never reaches 10; N sequence 100,90,80,80,90,100 (decel entered by rem/ramp rule).
  - done after 6 steps.
- steps=0, start: no drv_en_SM, done pulses at t+1, busy only in the STOP cycle.
- Abort after 3 steps of a 50-step move: drv_en_SM=0 the next cycle, done=1, aborted=1, step_cnt=3.
  - A new start clears aborted.
- Reset (rst=0) in CRUISE: all outputs zero next cycle, no done. start after release runs normally.
- Corner inputs:
  - n_min=200 > n_start=100: constant N=100.
  - acc=0: treated as 1.
  - start pulsed while busy: ignored.
  - step_fb held high for 5 cycles: counts exactly 1 step.
